gpio_pixel_packer: RTL

//  Downstream consumer of the data memory's GPIO port. Captures per-channel R/G/B words

---
 rtl/gpio_pixel_packer_if.sv | 28 ++
 rtl/gpio_pixel_packer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/gpio_pixel_packer_if.sv
// Bundles the GPIO channel strobes and the pixel stream of gpio_pixel_packer.
// master = packer side, slave = producer/consumer side.
`default_nettype none

interface gpio_pixel_packer_if #(
  parameter int CH_W = 8
);
  logic [31:0]       GPIO;
  logic              GPIOEnR;
  logic              GPIOEnG;
  logic              GPIOEnB;
  logic [3*CH_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  modport master (
    input  GPIO, GPIOEnR, GPIOEnG, GPIOEnB, pix_ready,
    output pix_data, pix_valid, pix_last
  );

  modport slave (
    output GPIO, GPIOEnR, GPIOEnG, GPIOEnB, pix_ready,
    input  pix_data, pix_valid, pix_last
  );
endinterface

`default_nettype wire

// File: rtl/gpio_pixel_packer.sv
// ---------------------------------------------------------------------------
// gpio_pixel_packer: saturates R/G/B GPIO words, packs pixels, FWFT FIFO out.
// Optional macro PIX_FRAME_EN enables the frame counter driving pix_last.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpio_pixel_packer #(
  parameter int DEPTH        = 16,
  parameter int CH_W         = 8,
  parameter int FRAME_PIXELS = 307200
) (
  input  wire logic               clk,
  input  wire logic               rst,
  gpio_pixel_packer_if.master     bus,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    seq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 3 * CH_W;

  typedef enum logic [1:0] {EXP_R = 2'd0, EXP_G = 2'd1, EXP_B = 2'd2} state_t;

  state_t          state, state_nxt;
  logic            cap_r, cap_g, push, err_nxt;
  logic [CH_W-1:0] sat, r_ch, g_ch;
  logic [PW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            pop, push_ok;

  assign sat = (bus.GPIO[31:CH_W] != '0) ? {CH_W{1'b1}} : bus.GPIO[CH_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EXP_R;
      r_ch    <= '0;
      g_ch    <= '0;
      seq_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      seq_err <= err_nxt;
      if (cap_r) r_ch <= sat;
      if (cap_g) g_ch <= sat;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_r     = 1'b0;
    cap_g     = 1'b0;
    push      = 1'b0;
    err_nxt   = 1'b0;
    case ({bus.GPIOEnR, bus.GPIOEnG, bus.GPIOEnB})
      3'b000: ;
      3'b100: begin
        cap_r     = 1'b1;
        state_nxt = EXP_G;
        err_nxt   = (state != EXP_R);
      end
      3'b010: begin
        if (state == EXP_G) begin
          cap_g     = 1'b1;
          state_nxt = EXP_B;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = EXP_R;
        end
      end
      3'b001: begin
        if (state == EXP_B) push = 1'b1;
        else                err_nxt = 1'b1;
        state_nxt = EXP_R;
      end
      default: err_nxt = 1'b1;  // simultaneous strobes: nothing captured, state held
    endcase
  end

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign bus.pix_valid = (fifo_count != '0);
  assign pop           = bus.pix_valid && bus.pix_ready;
  assign push_ok       = push && ((fifo_count < (AW+1)'(DEPTH)) || pop);
  assign bus.pix_data  = bus.pix_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {r_ch, g_ch, sat};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

`ifdef PIX_FRAME_EN
  localparam int FW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  logic [FW-1:0] frame_cnt;
  logic          at_last;

  assign at_last      = (frame_cnt == FW'(FRAME_PIXELS - 1));
  assign bus.pix_last = bus.pix_valid && at_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        frame_cnt <= '0;
    else if (pop)    frame_cnt <= at_last ? '0 : frame_cnt + 1'b1;
  end
`else
  // Frame length has no meaning without frame tracking; expression is constant 0.
  assign bus.pix_last = (FRAME_PIXELS < 0);
`endif
endmodule

`default_nettype wire
